// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program-counter sequencer resolving branches, jal/jalr/mret and misaligned-target traps.
module pc_seq_unit #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
  parameter int              CNT_W     = 64
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch,
  input  logic [2:0]       br_funct3,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic             jal,
  input  logic             jalr,
  input  logic             mret,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic [XLEN-1:0]  epc,
  output logic             trap_taken,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);
  if (RESET_VEC[1:0] != 2'b00) begin : g_bad_reset_vec
    $error("RESET_VEC must be 4-byte aligned");
  end
  if (TRAP_VEC[1:0] != 2'b00) begin : g_bad_trap_vec
    $error("TRAP_VEC must be 4-byte aligned");
  end
  typedef enum logic [1:0] {RUN, HANDLER, HALT} state_t;
  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d, epc_q, epc_d, jalr_sum, br_tgt, target;
  logic             trap_taken_q, trap_taken_d, halted_q, halted_d, taken, fault;
  logic [CNT_W-1:0] instret_q, instret_d;
  // funct3[2:1] picks the flag, funct3[0] inverts it; 01x never takes
  assign taken    = branch & (br_funct3[2:1] == 2'b01 ? 1'b0 :
                    ((br_funct3[2:1] == 2'b00 ? zero : br_funct3[1] ? ltu : lt) ^ br_funct3[0]));
  assign pc_plus4 = pc_q + XLEN'(4);
  assign jalr_sum = rs1 + imm;
  assign br_tgt   = pc_q + imm;
  assign target   = jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (jal | taken) ? br_tgt : pc_plus4;
  // mret outranks every redirect, so it also masks their misalignment
  assign fault    = ~mret & (jalr | jal | taken) & (|target[1:0]);
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    epc_d        = epc_q;
    trap_taken_d = 1'b0;
    halted_d     = halted_q;
    instret_d    = instret_q;
    if (state_q != HALT && !stall) begin
      if (fault && state_q == RUN) begin
        epc_d        = pc_q;
        pc_d         = TRAP_VEC;
        trap_taken_d = 1'b1;
        state_d      = HANDLER;
      end else if (fault) begin
        halted_d = 1'b1;
        state_d  = HALT;
      end else begin
        instret_d = instret_q + CNT_W'(1);
        pc_d      = !mret ? target : state_q == HANDLER ? epc_q + XLEN'(4) : pc_plus4;
        state_d   = mret && state_q == HANDLER ? RUN : state_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_VEC;
      epc_q        <= '0;
      trap_taken_q <= 1'b0;
      halted_q     <= 1'b0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      trap_taken_q <= trap_taken_d;
      halted_q     <= halted_d;
      instret_q    <= instret_d;
    end
  end
  assign pc         = pc_q;
  assign epc        = epc_q;
  assign trap_taken = trap_taken_q;
  assign halted     = halted_q;
  assign instret    = instret_q;
endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed vector table plus hand sequences for halt, async reset and wrap.
module tb_pc_seq_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 0, branch = 0, zero = 0, lt = 0, ltu = 0, jal = 0, jalr = 0, mret = 0;
  logic [2:0]  br_funct3 = '0;
  logic [63:0] imm = '0, rs1 = '0;
  logic [63:0] pc, pc_plus4, epc, instret;
  logic        trap_taken, halted;
  int          tests = 0, fails = 0;
  pc_seq_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .br_funct3(br_funct3),
    .zero(zero), .lt(lt), .ltu(ltu), .jal(jal), .jalr(jalr), .mret(mret),
    .imm(imm), .rs1(rs1), .pc(pc), .pc_plus4(pc_plus4), .epc(epc),
    .trap_taken(trap_taken), .halted(halted), .instret(instret)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic s, b; logic [2:0] f; logic z, l, u, j, jr, m;
    logic [63:0] imm, rs1, pc, epc; logic t, h; logic [63:0] n;
  } vec_t;
  vec_t v[26];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic s, b, input logic [2:0] f, input logic z, l, u, j, jr, m,
                       input logic [63:0] im, r);
    stall = s; branch = b; br_funct3 = f; zero = z; lt = l; ltu = u;
    jal = j; jalr = jr; mret = m; imm = im; rs1 = r;
  endtask
  task automatic check_all(input string tag, input logic [63:0] p, e, input logic t, h,
                           input logic [63:0] n);
    check({tag, " pc"}, pc, p);
    check({tag, " pc_plus4"}, pc_plus4, p + 64'd4);
    check({tag, " epc"}, epc, e);
    check({tag, " trap_taken"}, {63'd0, trap_taken}, {63'd0, t});
    check({tag, " halted"}, {63'd0, halted}, {63'd0, h});
    check({tag, " instret"}, instret, n);
  endtask
  initial begin
    //        s b f   z l u j jr m  imm        rs1        pc         epc    t h n
    v[0]  = '{0,0,0,  0,0,0,0,0, 0, 0,         0,         'h4,       0,     0,0,1};
    v[1]  = '{0,0,0,  0,0,0,0,0, 0, 0,         0,         'h8,       0,     0,0,2};
    v[2]  = '{0,0,0,  0,0,0,0,0, 0, 0,         0,         'hc,       0,     0,0,3};
    v[3]  = '{0,0,0,  0,0,0,1,0, 0, 'h14,      0,         'h20,      0,     0,0,4};
    v[4]  = '{0,1,1,  0,0,0,0,0, 0, -64'd8,    0,         'h18,      0,     0,0,5};
    v[5]  = '{0,0,0,  0,0,0,1,0, 0, 'h8,       0,         'h20,      0,     0,0,6};
    v[6]  = '{0,1,1,  1,0,0,0,0, 0, -64'd8,    0,         'h24,      0,     0,0,7};
    v[7]  = '{0,1,0,  1,0,0,0,0, 0, 'h10,      0,         'h34,      0,     0,0,8};
    v[8]  = '{0,1,4,  0,0,0,0,0, 0, 'h40,      0,         'h38,      0,     0,0,9};
    v[9]  = '{0,1,5,  0,0,0,0,0, 0, 'h8,       0,         'h40,      0,     0,0,10};
    v[10] = '{0,1,6,  0,0,1,0,0, 0, -64'h10,   0,         'h30,      0,     0,0,11};
    v[11] = '{0,1,7,  0,0,1,0,0, 0, 'h100,     0,         'h34,      0,     0,0,12};
    v[12] = '{0,1,2,  1,0,0,0,0, 0, 'h100,     0,         'h38,      0,     0,0,13};
    v[13] = '{0,1,3,  1,1,1,0,0, 0, 'h2,       0,         'h3c,      0,     0,0,14};
    v[14] = '{0,0,0,  0,0,0,0,1, 0, 'h4,       'h1001,    'h1004,    0,     0,0,15};
    v[15] = '{0,0,0,  0,0,0,1,0, 0, -64'hfc4,  0,         'h40,      0,     0,0,16};
    v[16] = '{0,0,0,  0,0,0,1,0, 0, 'h6,       0,         'h100,     'h40,  1,0,16};
    v[17] = '{0,0,0,  0,0,0,0,0, 0, 0,         0,         'h104,     'h40,  0,0,17};
    v[18] = '{0,0,0,  0,0,0,1,0, 1, 'h2,       0,         'h44,      'h40,  0,0,18};
    v[19] = '{1,0,0,  0,0,0,1,0, 0, 'h8,       0,         'h44,      'h40,  0,0,18};
    v[20] = '{1,0,0,  0,0,0,1,0, 0, 'h8,       0,         'h44,      'h40,  0,0,18};
    v[21] = '{1,0,0,  0,0,0,1,0, 0, 'h8,       0,         'h44,      'h40,  0,0,18};
    v[22] = '{0,0,0,  0,0,0,0,1, 0, 0,         'h102,     'h100,     'h44,  1,0,18};
    v[23] = '{1,0,0,  0,0,0,0,0, 0, 0,         0,         'h100,     'h44,  0,0,18};
    v[24] = '{0,0,0,  0,0,0,1,0, 0, 'h2,       0,         'h100,     'h44,  0,1,18};
    v[25] = '{0,0,0,  0,0,0,1,0, 0, 'h8,       0,         'h100,     'h44,  0,1,18};
    #12;
    check_all("reset", 64'h0, 64'h0, 1'b0, 1'b0, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    foreach (v[i]) begin
      drive(v[i].s, v[i].b, v[i].f, v[i].z, v[i].l, v[i].u, v[i].j, v[i].jr, v[i].m, v[i].imm, v[i].rs1);
      step();
      check_all($sformatf("vec%0d", i), v[i].pc, v[i].epc, v[i].t, v[i].h, v[i].n);
    end
    for (int i = 0; i < 10; i++) begin
      drive(i[0], 0, 0, 0, 0, 0, ~i[0], 0, i[0], 64'h8, 0);
      step();
      check($sformatf("halt%0d pc", i), pc, 64'h100);
      check($sformatf("halt%0d halted", i), {63'd0, halted}, 64'd1);
      check($sformatf("halt%0d instret", i), instret, 64'd18);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 64'h40, 0);
    #3 rst_n = 1'b0;
    #1;
    check_all("async reset", 64'h0, 64'h0, 1'b0, 1'b0, 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    check_all("post reset", 64'h4, 64'h0, 1'b0, 1'b0, 64'd1);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, -64'd8, 0);
    step();
    check_all("to top", 64'hffff_ffff_ffff_fffc, 64'h0, 1'b0, 1'b0, 64'd2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check_all("wrap", 64'h0, 64'h0, 1'b0, 1'b0, 64'd3);
    drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 64'h22, 0);
    step();
    check_all("branch fault", 64'h100, 64'h0, 1'b1, 1'b0, 64'd3);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check_all("stall clears trap", 64'h100, 64'h0, 1'b0, 1'b0, 64'd3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
